ret_addr_stack: RTL and testbench

//  Return address stack (RAS) that predicts targets for return-type jumps in the fetch stage.
//  - Speculative stack: updated at fetch by decoded call/return flags; drives ret_v/ret_pc to fetch-PC selection.
//  - Committed stack: updated at commit by call/return commit flags.
//  - On a writeback flush, the speculative stack is restored from the committed stack.

---
 rtl/ret_addr_stack_pkg.sv | 27 ++
 rtl/ret_addr_stack_ras_stack.sv | 80 ++++++++
 rtl/ret_addr_stack.sv | 106 ++++++++++
 tb/tb_ret_addr_stack.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ret_addr_stack_pkg.sv
// Shared types and defaults for the return address stack.
package ret_addr_stack_pkg;

    localparam int ADDR_WIDTH    = 32;
    localparam int RAS_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        RAS_NOP,
        RAS_PUSH,
        RAS_POP,
        RAS_REPL
    } RasOp_t;

    // Map active-low call/return flags to a stack operation; both set means
    // the instruction returns and calls in one go, so the top is replaced.
    function automatic RasOp_t ras_op_enc(input logic call_, input logic return_);
        RasOp_t op;
        case ({call_, return_})
            2'b01:   op = RAS_PUSH;
            2'b10:   op = RAS_POP;
            2'b00:   op = RAS_REPL;
            default: op = RAS_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ret_addr_stack_ras_stack.sv
// One circular return-address stack. Exposes its registered state and the
// state it will take on the next edge; a restore input overrides the update
// with a full externally supplied state.
module ras_stack
    import ret_addr_stack_pkg::*;
#(
    parameter  int ADDR      = ADDR_WIDTH,
    parameter  int RAS_DEPTH = RAS_DEPTH_DEF,
    localparam int PTR       = $clog2(RAS_DEPTH)
) (
    input  logic                            clk,
    input  logic                            reset_,
    input  RasOp_t                          op,
    input  logic [ADDR-1:0]                 wdata,
    input  logic                            restore,
    input  logic [RAS_DEPTH-1:0][ADDR-1:0]  rst_entries,
    input  logic [PTR-1:0]                  rst_tp,
    input  logic [PTR:0]                    rst_cnt,
    output logic [RAS_DEPTH-1:0][ADDR-1:0]  entries,
    output logic [PTR-1:0]                  tp,
    output logic [PTR:0]                    cnt,
    output logic [RAS_DEPTH-1:0][ADDR-1:0]  nxt_entries,
    output logic [PTR-1:0]                  nxt_tp,
    output logic [PTR:0]                    nxt_cnt
);

    localparam logic [PTR:0] CNT_FULL = (PTR+1)'(RAS_DEPTH);

    logic [PTR-1:0] tp_m1;
    assign tp_m1 = tp - 1'b1;

    // Next-state: push wraps and overwrites the oldest entry when full,
    // pop on empty is ignored, replace on empty degenerates to a push.
    always_comb begin
        nxt_entries = entries;
        nxt_tp      = tp;
        nxt_cnt     = cnt;
        case (op)
            RAS_PUSH: begin
                nxt_entries[tp] = wdata;
                nxt_tp          = tp + 1'b1;
                if (cnt != CNT_FULL) nxt_cnt = cnt + 1'b1;
            end
            RAS_POP: begin
                if (cnt != '0) begin
                    nxt_tp  = tp_m1;
                    nxt_cnt = cnt - 1'b1;
                end
            end
            RAS_REPL: begin
                if (cnt == '0) begin
                    nxt_entries[tp] = wdata;
                    nxt_tp          = tp + 1'b1;
                    nxt_cnt         = cnt + 1'b1;
                end else begin
                    nxt_entries[tp_m1] = wdata;
                end
            end
            default: ;
        endcase
    end

    // State register; restore takes priority over the local update.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            entries <= '0;
            tp      <= '0;
            cnt     <= '0;
        end else if (restore) begin
            entries <= rst_entries;
            tp      <= rst_tp;
            cnt     <= rst_cnt;
        end else begin
            entries <= nxt_entries;
            tp      <= nxt_tp;
            cnt     <= nxt_cnt;
        end
    end

endmodule

// File: rtl/ret_addr_stack.sv
// Return address stack: a speculative stack updated at fetch that predicts
// return targets, and a committed stack updated at commit that repairs the
// speculative one on a writeback flush.
// Optional build macro RAS_STAT_EN adds overflow/underflow event counters.
module ret_addr_stack
    import ret_addr_stack_pkg::*;
#(
    parameter  int ADDR      = ADDR_WIDTH,
    parameter  int RAS_DEPTH = RAS_DEPTH_DEF,
    localparam int PTR       = $clog2(RAS_DEPTH)
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            inst_e_,
    input  logic [ADDR-1:0] inst_pc,
    input  logic            inst_call_,
    input  logic            inst_return_,
    output logic            ret_v,
    output logic [ADDR-1:0] ret_pc,
`ifdef RAS_STAT_EN
    output logic [31:0]     ras_ovf_cnt,
    output logic [31:0]     ras_udf_cnt,
`endif
    input  logic            wb_flush_,
    input  logic            commit_e_,
    input  logic            jump_call_,
    input  logic            jump_return_,
    input  logic [ADDR-1:0] com_ft_addr
);

    RasOp_t spec_op, com_op;

    logic [RAS_DEPTH-1:0][ADDR-1:0] spec_entries, spec_nxt_entries;
    logic [PTR-1:0]                 spec_tp, spec_nxt_tp;
    logic [PTR:0]                   spec_cnt, spec_nxt_cnt;
    logic [RAS_DEPTH-1:0][ADDR-1:0] com_entries, com_nxt_entries;
    logic [PTR-1:0]                 com_tp, com_nxt_tp;
    logic [PTR:0]                   com_cnt, com_nxt_cnt;
    logic [PTR-1:0]                 spec_top;

    // Fetch updates are dropped during a flush; the restore wins instead.
    always_comb begin
        spec_op = RAS_NOP;
        com_op  = RAS_NOP;
        if (!inst_e_ && wb_flush_) spec_op = ras_op_enc(inst_call_, inst_return_);
        if (!commit_e_)            com_op  = ras_op_enc(jump_call_, jump_return_);
    end

    ras_stack #(.ADDR(ADDR), .RAS_DEPTH(RAS_DEPTH)) u_spec (
        .clk         (clk),
        .reset_      (reset_),
        .op          (spec_op),
        .wdata       (inst_pc + ADDR'(4)),
        .restore     (!wb_flush_),
        .rst_entries (com_nxt_entries),
        .rst_tp      (com_nxt_tp),
        .rst_cnt     (com_nxt_cnt),
        .entries     (spec_entries),
        .tp          (spec_tp),
        .cnt         (spec_cnt),
        .nxt_entries (spec_nxt_entries),
        .nxt_tp      (spec_nxt_tp),
        .nxt_cnt     (spec_nxt_cnt)
    );

    ras_stack #(.ADDR(ADDR), .RAS_DEPTH(RAS_DEPTH)) u_com (
        .clk         (clk),
        .reset_      (reset_),
        .op          (com_op),
        .wdata       (com_ft_addr),
        .restore     (1'b0),
        .rst_entries ('0),
        .rst_tp      ('0),
        .rst_cnt     ('0),
        .entries     (com_entries),
        .tp          (com_tp),
        .cnt         (com_cnt),
        .nxt_entries (com_nxt_entries),
        .nxt_tp      (com_nxt_tp),
        .nxt_cnt     (com_nxt_cnt)
    );

    assign spec_top = spec_tp - 1'b1;
    assign ret_pc   = spec_entries[spec_top];
    assign ret_v    = (spec_cnt != '0);

`ifdef RAS_STAT_EN
    localparam logic [PTR:0] CNT_FULL = (PTR+1)'(RAS_DEPTH);

    logic spec_ovf, spec_udf;
    assign spec_ovf = (spec_op == RAS_PUSH) && (spec_cnt == CNT_FULL);
    assign spec_udf = (spec_op == RAS_POP)  && (spec_cnt == '0);

    // Free-running event counters; a flush leaves them untouched.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ras_ovf_cnt <= '0;
            ras_udf_cnt <= '0;
        end else begin
            if (spec_ovf) ras_ovf_cnt <= ras_ovf_cnt + 32'd1;
            if (spec_udf) ras_udf_cnt <= ras_udf_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed bench for ret_addr_stack; expected prediction outputs are queued
// with each step and compared after the clock edge that applies it.
module tb_ret_addr_stack;

    logic        clk;
    logic        reset_;
    logic        inst_e_;
    logic [31:0] inst_pc;
    logic        inst_call_;
    logic        inst_return_;
    logic        ret_v;
    logic [31:0] ret_pc;
    logic        wb_flush_;
    logic        commit_e_;
    logic        jump_call_;
    logic        jump_return_;
    logic [31:0] com_ft_addr;
`ifdef RAS_STAT_EN
    logic [31:0] ras_ovf_cnt;
    logic [31:0] ras_udf_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic        v;
        logic [31:0] pc;
    } exp_t;
    exp_t sb[$];

    ret_addr_stack dut (
        .clk          (clk),
        .reset_       (reset_),
        .inst_e_      (inst_e_),
        .inst_pc      (inst_pc),
        .inst_call_   (inst_call_),
        .inst_return_ (inst_return_),
        .ret_v        (ret_v),
        .ret_pc       (ret_pc),
`ifdef RAS_STAT_EN
        .ras_ovf_cnt  (ras_ovf_cnt),
        .ras_udf_cnt  (ras_udf_cnt),
`endif
        .wb_flush_    (wb_flush_),
        .commit_e_    (commit_e_),
        .jump_call_   (jump_call_),
        .jump_return_ (jump_return_),
        .com_ft_addr  (com_ft_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        inst_e_      = 1'b1;
        inst_call_   = 1'b1;
        inst_return_ = 1'b1;
        inst_pc      = '0;
        wb_flush_    = 1'b1;
        commit_e_    = 1'b1;
        jump_call_   = 1'b1;
        jump_return_ = 1'b1;
        com_ft_addr  = '0;
    endtask

    task automatic fetch(input logic call_, input logic ret_, input logic [31:0] pc);
        inst_e_      = 1'b0;
        inst_call_   = call_;
        inst_return_ = ret_;
        inst_pc      = pc;
    endtask

    task automatic commit(input logic call_, input logic ret_, input logic [31:0] ft);
        commit_e_    = 1'b0;
        jump_call_   = call_;
        jump_return_ = ret_;
        com_ft_addr  = ft;
    endtask

    task automatic check_now(input string tag, input logic ev, input logic [31:0] epc);
        vectors++;
        assert (ret_v === ev && ret_pc === epc) else begin
            miscompares++;
            $error("FAIL %s: observed v=%0b pc=%h expected v=%0b pc=%h", tag, ret_v, ret_pc, ev, epc);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Apply the currently driven inputs for one cycle, then compare.
    task automatic step(input string tag, input logic ev, input logic [31:0] epc);
        exp_t e;
        e.tag = tag; e.v = ev; e.pc = epc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_now(e.tag, e.v, e.pc);
        idle();
    endtask

    initial begin
        idle();
        reset_ = 1'b0;
        #12;
        check_now("reset", 1'b0, 32'h0);
        @(negedge clk);
        reset_ = 1'b1;

        // 1: basic push/pop
        fetch(1'b0, 1'b1, 32'h100); step("t1_call_100", 1'b1, 32'h104);
        fetch(1'b0, 1'b1, 32'h200); step("t1_call_200", 1'b1, 32'h204);
        inst_e_ = 1'b1; inst_call_ = 1'b0; inst_pc = 32'h300;
        step("t1_not_valid", 1'b1, 32'h204);
        fetch(1'b1, 1'b0, 32'h0);   step("t1_ret1", 1'b1, 32'h104);
        fetch(1'b1, 1'b0, 32'h0);   step("t1_ret2", 1'b0, 32'h0);

        // 2: overflow and underflow (tp ends at 1, slot 0 holds 0x94)
        for (int k = 1; k <= 9; k++) begin
            fetch(1'b0, 1'b1, 32'(k * 16));
            step($sformatf("t2_call_%0d", k), 1'b1, 32'(k * 16 + 4));
        end
        for (int j = 1; j <= 7; j++) begin
            fetch(1'b1, 1'b0, 32'h0);
            step($sformatf("t2_ret_%0d", j), 1'b1, 32'((9 - j) * 16 + 4));
        end
        fetch(1'b1, 1'b0, 32'h0); step("t2_ret_8_empty", 1'b0, 32'h94);
        fetch(1'b1, 1'b0, 32'h0); step("t2_ret_9_udf", 1'b0, 32'h94);
`ifdef RAS_STAT_EN
        check_val("t2_udf_cnt", ras_udf_cnt, 32'd1);
        check_val("t2_ovf_cnt", ras_ovf_cnt, 32'd1);
`endif

        // 3: flush restores committed stack {0x104}; fetch call in flush dropped
        commit(1'b0, 1'b1, 32'h104); step("t3_commit", 1'b0, 32'h94);
        fetch(1'b0, 1'b1, 32'h300);  step("t3_call_300", 1'b1, 32'h304);
        fetch(1'b0, 1'b1, 32'h400);  step("t3_call_400", 1'b1, 32'h404);
        fetch(1'b0, 1'b1, 32'h700); wb_flush_ = 1'b0;
        step("t3_flush", 1'b1, 32'h104);
        fetch(1'b1, 1'b0, 32'h0);    step("t3_pop_empty", 1'b0, 32'h0);

        // 4: flush together with a commit call
        commit(1'b0, 1'b1, 32'h504); wb_flush_ = 1'b0;
        step("t4_flush_commit", 1'b1, 32'h504);
        fetch(1'b1, 1'b0, 32'h0);    step("t4_pop1", 1'b1, 32'h104);
        fetch(1'b1, 1'b0, 32'h0);    step("t4_pop2", 1'b0, 32'h0);

        // 5: call+return replaces in place; on empty acts as a push
        fetch(1'b0, 1'b1, 32'h100);  step("t5_call_100", 1'b1, 32'h104);
        fetch(1'b0, 1'b0, 32'h600);  step("t5_callret", 1'b1, 32'h604);
        fetch(1'b1, 1'b0, 32'h0);    step("t5_pop", 1'b0, 32'h0);
        fetch(1'b0, 1'b0, 32'h600);  step("t5_callret_empty", 1'b1, 32'h604);
        fetch(1'b1, 1'b0, 32'h0);    step("t5_pop_empty", 1'b0, 32'h0);

        // commit-side pop seen through a flush, then independent fetch/commit
        commit(1'b1, 1'b0, 32'h0); wb_flush_ = 1'b0;
        step("tc_commit_pop_flush", 1'b1, 32'h104);
        fetch(1'b0, 1'b1, 32'h800); commit(1'b0, 1'b1, 32'h904);
        step("tc_independent", 1'b1, 32'h804);
        wb_flush_ = 1'b0;            step("tc_flush2", 1'b1, 32'h904);
        fetch(1'b1, 1'b0, 32'h0);    step("tc_pop1", 1'b1, 32'h104);
        fetch(1'b1, 1'b0, 32'h0);    step("tc_pop2", 1'b0, 32'h0);

        // 6: address wrap, then asynchronous reset mid-sequence
        fetch(1'b0, 1'b1, 32'hFFFF_FFFC); step("t6_wrap", 1'b1, 32'h0);
        fetch(1'b0, 1'b1, 32'h1000);      step("t6_call_1000", 1'b1, 32'h1004);
        #2;
        reset_ = 1'b0;
        #1;
        check_now("t6_async_reset", 1'b0, 32'h0);
`ifdef RAS_STAT_EN
        check_val("t6_udf_reset", ras_udf_cnt, 32'd0);
        check_val("t6_ovf_reset", ras_ovf_cnt, 32'd0);
`endif
        @(negedge clk);
        reset_ = 1'b1;
        step("t6_after_reset", 1'b0, 32'h0);
        fetch(1'b1, 1'b0, 32'h0);         step("t6_pop_after_reset", 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
